// File: rtl/strength_bus_arbiter.sv
// Round-robin owner of one resolved bus net: the granted requester drives it strong, an idle pull driver holds it otherwise.
// Define STRENGTH_BUS_KEEPER_EN to make the idle driver a keeper of the last granted value instead of a constant 0.
module strength_bus_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_MAX    = 15,
  parameter int TURN_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           done,
  input  logic [NREQ*WIDTH-1:0]     data_i,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic [WIDTH-1:0]          bus_o,
  output logic                      bus_valid,
  output logic                      timeout_o
);

  localparam int OW = $clog2(NREQ);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [2:0] TURN_LOAD = 3'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_TURN
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [NREQ-1:0] gnt_next;
  logic [OW-1:0]   owner_next;
  logic [OW-1:0]   ptr;
  logic [OW-1:0]   ptr_next;
  logic [7:0]      hold_cnt;
  logic [7:0]      hold_next;
  logic [2:0]      turn_cnt;
  logic [2:0]      turn_next;
  logic            timeout_next;
  logic [OW-1:0]   cand;
  logic [OW-1:0]   pick;
  logic            pick_ok;
  logic [WIDTH-1:0] owner_data;
  logic [WIDTH-1:0] slices [NREQ];
  logic [WIDTH-1:0] idle_val;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slices[i] = data_i[i*WIDTH +: WIDTH];
  end

  assign owner_data = slices[owner];
  assign bus_valid  = (state == ST_GRANT);

  // Search starts just past the last owner, so that owner always ranks last.
  always_comb begin
    cand    = '0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = OW'((int'(ptr) + k) % NREQ);
      if (!pick_ok && req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    owner_next   = owner;
    ptr_next     = ptr;
    hold_next    = hold_cnt;
    turn_next    = turn_cnt;
    timeout_next = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_ok) begin
          state_next     = ST_GRANT;
          owner_next     = pick;
          ptr_next       = pick;
          gnt_next       = '0;
          gnt_next[pick] = 1'b1;
          hold_next      = '0;
        end
      end
      ST_GRANT: begin
        hold_next = hold_cnt + 8'd1;
        // A voluntary release on the limit cycle is not reported as a timeout.
        if (done[owner] || !req[owner] || (hold_cnt == HOLD_LAST)) begin
          state_next   = ST_TURN;
          gnt_next     = '0;
          turn_next    = TURN_LOAD;
          timeout_next = !(done[owner] || !req[owner]);
        end
      end
      ST_TURN: begin
        if (turn_cnt == 3'd0) begin
          state_next = ST_IDLE;
        end else begin
          turn_next = turn_cnt - 3'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      owner     <= '0;
      ptr       <= OW'(NREQ - 1);
      hold_cnt  <= '0;
      turn_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_next;
      gnt       <= gnt_next;
      owner     <= owner_next;
      ptr       <= ptr_next;
      hold_cnt  <= hold_next;
      turn_cnt  <= turn_next;
      timeout_o <= timeout_next;
    end
  end

`ifdef STRENGTH_BUS_KEEPER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_val <= '0;
    end else if (bus_valid) begin
      idle_val <= owner_data;
    end
  end
`else
  assign idle_val = '0;
`endif

  // The strong grant driver overrides the pull driver whenever it is not high-impedance.
  wire [WIDTH-1:0] shared_bus;
  assign (strong1, strong0) shared_bus = bus_valid ? owner_data : {WIDTH{1'bz}};
  assign (pull1, pull0)     shared_bus = idle_val;
  assign bus_o = shared_bus;

endmodule

// File: tb/tb_strength_bus_arbiter.sv
// Directed bench for strength_bus_arbiter with a cycle-level ownership model checked on every falling edge.
module tb_strength_bus_arbiter;

  localparam int NREQ        = 4;
  localparam int WIDTH       = 8;
  localparam int HOLD_MAX    = 15;
  localparam int TURN_CYCLES = 1;
`ifdef STRENGTH_BUS_KEEPER_EN
  localparam bit KEEPER = 1'b1;
`else
  localparam bit KEEPER = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       done;
  logic [NREQ*WIDTH-1:0] data_i;
  logic [NREQ-1:0]       gnt;
  logic [1:0]            owner;
  logic [WIDTH-1:0]      bus_o;
  logic                  bus_valid;
  logic                  timeout_o;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  strength_bus_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX), .TURN_CYCLES(TURN_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .data_i(data_i),
    .gnt(gnt), .owner(owner), .bus_o(bus_o), .bus_valid(bus_valid), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
    req  = r;
    done = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ownership model: who holds the bus, for how long, and how many quiet cycles remain.
  int         m_busy    = 0;
  int         m_held    = 0;
  int         m_gap     = 0;
  int         m_last    = NREQ - 1;
  int         m_owner   = 0;
  logic       m_timeout = 1'b0;
  logic [7:0] m_keep    = 8'h00;

  function automatic logic [WIDTH-1:0] slice_of(input int i);
    return WIDTH'(data_i >> (i * WIDTH));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_held = 0; m_gap = 0; m_last = NREQ - 1; m_owner = 0;
      m_timeout = 1'b0; m_keep = 8'h00;
    end else begin
      m_timeout = 1'b0;
      if (m_busy != 0) begin
        m_keep = slice_of(m_owner);
        m_held++;
        if (((done >> m_owner) & 1) != 0 || ((req >> m_owner) & 1) == 0) begin
          m_busy = 0; m_gap = TURN_CYCLES;
        end else if (m_held == HOLD_MAX) begin
          m_busy = 0; m_gap = TURN_CYCLES; m_timeout = 1'b1;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (m_busy == 0 && ((req >> ((m_last + k) % NREQ)) & 1) != 0) begin
            m_owner = (m_last + k) % NREQ;
            m_busy  = 1;
          end
        end
        m_last = m_owner;
        m_held = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      checkOutput("gnt", 32'(gnt), (m_busy != 0) ? (32'd1 << m_owner) : 32'd0);
      checkOutput("bus_valid", 32'(bus_valid), 32'(m_busy != 0));
      checkOutput("owner", 32'(owner), 32'(m_owner));
      checkOutput("timeout_o", 32'(timeout_o), 32'(m_timeout));
      checkOutput("bus_o", 32'(bus_o),
                  (m_busy != 0) ? 32'(slice_of(m_owner)) : (KEEPER ? 32'(m_keep) : 32'd0));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [1:0] rr_owner [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rr_gnt   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int held;
    int guard;
    rst_n  = 1'b0;
    req    = '0;
    done   = '0;
    data_i = {8'h44, 8'hA5, 8'h22, 8'h11};
    #2;
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_valid", 32'(bus_valid), 32'h0);
    checkOutput("reset_owner", 32'(owner), 32'h0);
    checkOutput("reset_bus", 32'(bus_o), 32'h00);
    checkOutput("reset_timeout", 32'(timeout_o), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    $display("[TB] round robin with all requesters active");
    applyStimulus(4'b1111, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("rr_owner", 32'(owner), 32'(rr_owner[i]));
      checkOutput("rr_gnt", 32'(gnt), 32'(rr_gnt[i]));
      applyStimulus(4'b1111, rr_gnt[i]);
      tick();
      checkOutput("rr_turn_valid", 32'(bus_valid), 32'h0);
      applyStimulus(4'b1111, 4'b0000);
      tick();
      checkOutput("rr_idle_valid", 32'(bus_valid), 32'h0);
    end
    applyStimulus(4'b0000, 4'b0000);
    tick();

    $display("[TB] single request from requester 2");
    applyStimulus(4'b0100, 4'b0000);
    tick();
    checkOutput("single_gnt", 32'(gnt), 32'h4);
    checkOutput("single_bus", 32'(bus_o), 32'hA5);
    checkOutput("single_valid", 32'(bus_valid), 32'h1);
    applyStimulus(4'b0100, 4'b0100);
    tick();
    checkOutput("single_release_bus", 32'(bus_o), KEEPER ? 32'hA5 : 32'h00);
    checkOutput("single_release_gnt", 32'(gnt), 32'h0);
    applyStimulus(4'b0000, 4'b0000);
    tick();

    $display("[TB] forced release of requester 3");
    applyStimulus(4'b1001, 4'b0000);
    tick();
    checkOutput("timeout_owner", 32'(owner), 32'h3);
    held  = (bus_valid === 1'b1) ? 1 : 0;
    guard = 0;
    while (bus_valid === 1'b1 && guard < 30) begin
      tick();
      guard++;
      if (bus_valid === 1'b1) held++;
    end
    checkOutput("timeout_hold_cycles", 32'(held), 32'd15);
    checkOutput("timeout_pulse", 32'(timeout_o), 32'h1);
    tick();
    checkOutput("timeout_pulse_end", 32'(timeout_o), 32'h0);
    tick();
    checkOutput("timeout_next_owner", 32'(owner), 32'h0);
    checkOutput("timeout_next_gnt", 32'(gnt), 32'h1);
    applyStimulus(4'b1000, 4'b0000);
    tick();
    checkOutput("drop_req_no_timeout", 32'(timeout_o), 32'h0);
    applyStimulus(4'b0000, 4'b0000);
    tick();

    $display("[TB] done on the limit cycle, then re-request with requester 2");
    applyStimulus(4'b0010, 4'b0000);
    tick();
    checkOutput("simul_owner", 32'(owner), 32'h1);
    repeat (14) tick();
    checkOutput("simul_still_valid", 32'(bus_valid), 32'h1);
    applyStimulus(4'b0110, 4'b0010);
    tick();
    checkOutput("simul_released", 32'(bus_valid), 32'h0);
    checkOutput("simul_no_timeout", 32'(timeout_o), 32'h0);
    applyStimulus(4'b0110, 4'b0000);
    tick();
    tick();
    checkOutput("simul_fair_owner", 32'(owner), 32'h2);
    checkOutput("simul_fair_gnt", 32'(gnt), 32'h4);

    $display("[TB] asynchronous reset while requester 1 owns the bus");
    applyStimulus(4'b0010, 4'b0100);
    tick();
    applyStimulus(4'b0010, 4'b0000);
    tick();
    tick();
    checkOutput("pre_reset_owner", 32'(owner), 32'h1);
    checkOutput("pre_reset_bus", 32'(bus_o), 32'h22);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_gnt", 32'(gnt), 32'h0);
    checkOutput("async_reset_valid", 32'(bus_valid), 32'h0);
    checkOutput("async_reset_bus", 32'(bus_o), 32'h00);
    checkOutput("async_reset_owner", 32'(owner), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/strength_bus_arbiter.md
# strength_bus_arbiter

Round-robin arbiter that shares one resolved, strength-specified bus net between `NREQ` requesters. The granted requester drives the net with `(strong1, strong0)`. An always-present idle driver holds it with `(pull1, pull0)`, so the bus never floats. The block sits between requester logic and any consumer of the shared net. It sequences ownership with a grant/hold/turnaround state machine and forces release after a bounded hold time.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: bus data width.
- `HOLD_MAX`, 15: maximum consecutive GRANT cycles per ownership, 1..255.
- `TURN_CYCLES`, 1: idle turnaround cycles between owners, 1..7.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in `NREQ`: request per requester; level-sensitive.
- `done` in `NREQ`: owner releases the bus; sampled only for the current owner.
- `data_i` in `NREQ*WIDTH`: requester data, slice i = `data_i[i*WIDTH +: WIDTH]`.
- `gnt` out `NREQ`: one-hot grant; registered.
- `owner` out `$clog2(NREQ)`: index of the current or last owner; registered.
- `bus_o` out `WIDTH`: resolved value of the shared net.
- `bus_valid` out 1: high while in GRANT.
- `timeout_o` out 1: one-cycle pulse on forced release.

## Operation
- Internal net `shared_bus` carries two drivers:
  - Grant driver: `(strong1, strong0)`, value `data_i[owner]` in GRANT, `'z` otherwise.
  - Idle driver: `(pull1, pull0)`, value `idle_val`.
- `bus_o` = `shared_bus`. The strong driver always wins in GRANT.
- State machine:
  - IDLE: if `|req`, select the first set bit searching from `ptr+1` upward, modulo `NREQ`. Load `owner`, set `ptr` = selected index, set `gnt[owner]`, clear the hold counter, go to GRANT. With no request, stay in IDLE.
  - GRANT: the hold counter increments each cycle.
    - Exit when `done[owner]`, or `!req[owner]`, or counter == `HOLD_MAX-1`.
    - The counter case pulses `timeout_o` for 1 cycle, but only if `done` and `req` do not also end the grant that cycle.
    - On exit: clear `gnt`, load the turnaround counter, go to TURN.
  - TURN: `gnt` = 0, `bus_valid` = 0. After `TURN_CYCLES` cycles go to IDLE. Requests are ignored during TURN.
- Fairness: the last owner has lowest priority in the next IDLE search, including when it re-requests immediately.
- `done`/`req` from non-owners are ignored in GRANT.

## Timing
- Reset (async, immediate):
  - State IDLE, `gnt` = 0, `owner` = 0, `ptr` = `NREQ-1` (requester 0 first).
  - `bus_valid` = 0, `timeout_o` = 0, `idle_val` = 0, so `bus_o` = 0.
- Reset mid-GRANT drops `gnt` and `bus_valid` asynchronously.
- Latency: `req` sampled at edge k in IDLE gives `gnt`/`bus_valid` high after edge k. `bus_o` follows `data_i[owner]` combinationally in the same cycle.
- Release: `done` sampled at edge m causes `gnt`/`bus_valid` to fall after edge m. The next grant is earliest after edge m+`TURN_CYCLES`+1.
- Maximum ownership: exactly `HOLD_MAX` cycles with `bus_valid` high.
- `timeout_o` is high in the first TURN cycle only.
- Minimum repeat period for the same requester under contention is `NREQ*(1+TURN_CYCLES+1)` cycles.

## Configuration
- `STRENGTH_BUS_KEEPER_EN` defined:
  - `idle_val` is a register loaded with `data_i[owner]` on every GRANT cycle.
  - The idle `(pull1, pull0)` driver acts as a bus keeper, so `bus_o` holds the last driven value through TURN/IDLE.
- Undefined:
  - `idle_val` is the constant 0, and `bus_o` = 0 whenever not in GRANT.
  - No keeper register is built.

## Test plan
- Reset: assert `rst_n`=0 while requester 1 owns the bus -> `gnt`=0, `bus_valid`=0, `bus_o`=0x00 before the next clock edge.
- Single request: `req[2]`=1, slice 2 = 0xA5 -> `gnt`=4'b0100 one cycle later, `bus_o`=0xA5, `bus_valid`=1. Pulse `done[2]` -> after the next edge, `bus_o`=0x00 (macro undefined) or 0xA5 (macro defined).
- Round robin: `req`=4'b1111 held, each owner pulses `done` in its first GRANT cycle -> owner sequence 0,1,2,3,0. Each grant is separated by 1 TURN cycle plus 1 IDLE cycle.
- Timeout: `req[3]` held, `done` never asserted, `HOLD_MAX`=15 -> `bus_valid` high for exactly 15 cycles, `timeout_o` pulses once, then `req[0]` (also pending) is granted next.
- Simultaneous events: owner 1 asserts `done[1]` on the same edge the counter reaches `HOLD_MAX-1` -> release occurs with `timeout_o`=0. Owner 1 re-requesting alongside `req[2]` -> requester 2 is granted first.
